// File: rtl/tone_detector.sv
// tone_detector: measures the period of an incoming square wave in clk cycles
// and decodes it to one of eight note indices. A note is reported only after
// two consecutive periods agree, and the tone is declared lost when no rising
// edge arrives within TIMEOUT cycles.
//
// Handshake: there is no backpressure. `update` is a one-cycle strobe that is
// high exactly in the cycle `period` (and possibly `valid`/`note`) take a new
// value. Consumers must sample `period` while `update` is high.
//
// The FSM state is held in `state` (type state_t) so checkers can bind to it.
module tone_detector #(
  parameter int unsigned W       = 18,
  parameter int unsigned HALF_0  = 47801,
  parameter int unsigned HALF_1  = 42589,
  parameter int unsigned HALF_2  = 37936,
  parameter int unsigned HALF_3  = 35816,
  parameter int unsigned HALF_4  = 31928,
  parameter int unsigned HALF_5  = 28409,
  parameter int unsigned HALF_6  = 25329,
  parameter int unsigned HALF_7  = 23900,
  parameter int unsigned TOL     = 64,
  parameter int unsigned TIMEOUT = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tone_in,
  output logic [2:0]   note,
  output logic         valid,
  output logic         no_tone,
  output logic [W-1:0] period,
  output logic         update
);

  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;

  localparam logic [W-1:0]        TMO   = W'(TIMEOUT);
  localparam logic signed [W:0]   TOL_S = (W+1)'(TOL);
  // Nominal full periods, one per note, in signed W+1 bits so the error
  // against a measured period never wraps.
  localparam logic signed [W:0]   NOM [8] = '{
    (W+1)'(2*HALF_0), (W+1)'(2*HALF_1), (W+1)'(2*HALF_2), (W+1)'(2*HALF_3),
    (W+1)'(2*HALF_4), (W+1)'(2*HALF_5), (W+1)'(2*HALF_6), (W+1)'(2*HALF_7)
  };

  state_t          state;
  logic            sync_1, sync_2, sync_2_d, edge_r;
  logic [W-1:0]    cnt;
  logic [W-1:0]    p_meas;
  logic [2:0]      cls;
  logic            match;
  logic signed [W:0] diff;
  logic [2:0]      cand;
  logic            cand_ok;

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
      edge_r   <= 1'b0;
    end else begin
      sync_1   <= tone_in;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
      edge_r   <= sync_2 & ~sync_2_d;
    end
  end

  // Free-running period counter: cleared on every edge, saturates at TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (edge_r) begin
      cnt <= '0;
    end else if (cnt != TMO) begin
      cnt <= cnt + W'(1);
    end
  end

  // The counter holds cycles-since-edge minus one; a saturated counter stays
  // saturated so an edge coincident with timeout measures as a non-match.
  assign p_meas = (cnt == TMO) ? TMO : cnt + W'(1);

  // Tolerance match against every note; iterating downwards lets the lowest
  // matching index win.
  always_comb begin
    cls   = 3'd0;
    match = 1'b0;
    diff  = '0;
    for (int k = 7; k >= 0; k--) begin
      diff = $signed({1'b0, p_meas}) - NOM[k];
      if ((diff <= TOL_S) && (diff >= -TOL_S)) begin
        match = 1'b1;
        cls   = 3'(k);
      end
    end
  end

  // Acquisition FSM with registered outputs: candidate capture, two-period
  // confirmation and loss-of-tone timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      note    <= 3'd0;
      valid   <= 1'b0;
      no_tone <= 1'b1;
      period  <= '0;
      update  <= 1'b0;
      cand    <= 3'd0;
      cand_ok <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          valid   <= 1'b0;
          no_tone <= 1'b1;
          if (edge_r) state <= FIRST;
        end
        FIRST: begin
          if (edge_r) begin
            period  <= p_meas;
            update  <= 1'b1;
            cand    <= cls;
            cand_ok <= match;
            no_tone <= 1'b0;
            state   <= TRACK;
          end else if (cnt == TMO) begin
            valid   <= 1'b0;
            no_tone <= 1'b1;
            state   <= IDLE;
          end
        end
        TRACK: begin
          if (edge_r) begin
            period <= p_meas;
            update <= 1'b1;
            if (match && cand_ok && (cls == cand)) begin
              valid <= 1'b1;
              note  <= cls;
            end else begin
              valid   <= 1'b0;
              cand    <= cls;
              cand_ok <= match;
            end
          end else if (cnt == TMO) begin
            valid   <= 1'b0;
            no_tone <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector. Note periods are scaled down (about 1/100)
// and W reduced to 10 so lock, tolerance and timeout all fit a short run.
module tb_tone_detector;

  localparam int W   = 10;
  localparam int TOL = 6;
  localparam int TMO = (1 << W) - 1;  // 1023

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tone_in = 1'b0;
  logic [2:0]   note;
  logic         valid;
  logic         no_tone;
  logic [W-1:0] period;
  logic         update;

  int n_tests = 0;
  int n_fail  = 0;

  // Every update strobe is logged with the outputs it came with.
  logic [W-1:0] q_per[$];
  logic         q_val[$];
  logic [2:0]   q_note[$];

  tone_detector #(
    .W(W), .HALF_0(478), .HALF_1(426), .HALF_2(379), .HALF_3(358),
    .HALF_4(319), .HALF_5(284), .HALF_6(253), .HALF_7(239),
    .TOL(TOL), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tone_in(tone_in), .note(note),
    .valid(valid), .no_tone(no_tone), .period(period), .update(update)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update) begin
      q_per.push_back(period);
      q_val.push_back(valid);
      q_note.push_back(note);
    end
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Driver tasks
  task automatic apply_reset();
    tone_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    q_per.delete(); q_val.delete(); q_note.delete();
  endtask

  task automatic run_periods(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1;
      repeat (hi) @(negedge clk);
      tone_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  // Rising edge that closes the last period; waits until its effects are visible.
  task automatic close_rise();
    tone_in = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (note !== 3'd0)    begin n_fail++; $display("FAIL reset_note: got %0d want 0", note); end
    n_tests++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (no_tone !== 1'b1) begin n_fail++; $display("FAIL reset_no_tone: got %b want 1", no_tone); end
    n_tests++; if (period !== '0)    begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
    n_tests++; if (update !== 1'b0)  begin n_fail++; $display("FAIL reset_update: got %b want 0", update); end
  endtask

  task automatic test_lock();
    logic ev [3] = '{1'b0, 1'b1, 1'b1};
    apply_reset();
    run_periods(478, 478, 3);
    close_rise();
    n_tests++;
    if (q_per.size() != 3) begin
      n_fail++; $display("FAIL lock_updates: got %0d want 3", q_per.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (q_per[i] !== 10'd956) begin n_fail++; $display("FAIL lock_period[%0d]: got %0d want 956", i, q_per[i]); end
        n_tests++; if (q_val[i] !== ev[i])  begin n_fail++; $display("FAIL lock_valid[%0d]: got %b want %b", i, q_val[i], ev[i]); end
      end
    end
    n_tests++; if (note !== 3'd0 || valid !== 1'b1 || no_tone !== 1'b0) begin
      n_fail++; $display("FAIL lock_state: got note=%0d valid=%b no_tone=%b want 0 1 0", note, valid, no_tone);
    end
  endtask

  task automatic test_note_change();
    logic [W-1:0] ep [6] = '{10'd956, 10'd956, 10'd956, 10'd478, 10'd478, 10'd478};
    logic         ev [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]   en [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};
    apply_reset();
    run_periods(478, 478, 3);
    run_periods(239, 239, 3);
    close_rise();
    n_tests++;
    if (q_per.size() != 6) begin
      n_fail++; $display("FAIL change_updates: got %0d want 6", q_per.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++; if (q_per[i] !== ep[i] || q_val[i] !== ev[i] || q_note[i] !== en[i]) begin
          n_fail++; $display("FAIL change[%0d]: got p=%0d v=%b n=%0d want p=%0d v=%b n=%0d",
                             i, q_per[i], q_val[i], q_note[i], ep[i], ev[i], en[i]);
        end
      end
    end
  endtask

  task automatic test_tolerance();
    // Nominal note 3 period is 716; 710 and 722 sit on the boundary, 709 and 723 just outside.
    logic [W-1:0] ep1 [4] = '{10'd710, 10'd710, 10'd710, 10'd723};
    logic [W-1:0] ep2 [4] = '{10'd722, 10'd722, 10'd722, 10'd709};
    logic         ev  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      if (pass == 0) begin run_periods(355, 355, 3); run_periods(362, 361, 1); end
      else           begin run_periods(361, 361, 3); run_periods(355, 354, 1); end
      close_rise();
      n_tests++;
      if (q_per.size() != 4) begin
        n_fail++; $display("FAIL tol_updates pass %0d: got %0d want 4", pass, q_per.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_tests++; if (q_per[i] !== ((pass == 0) ? ep1[i] : ep2[i]) || q_val[i] !== ev[i]) begin
            n_fail++; $display("FAIL tol[%0d][%0d]: got p=%0d v=%b want p=%0d v=%b", pass, i,
                               q_per[i], q_val[i], (pass == 0) ? ep1[i] : ep2[i], ev[i]);
          end
          if (i > 0) begin
            n_tests++; if (q_note[i] !== 3'd3) begin n_fail++; $display("FAIL tol_note[%0d][%0d]: got %0d want 3", pass, i, q_note[i]); end
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int j;
    apply_reset();
    run_periods(319, 319, 3);
    close_rise();
    n_tests++; if (valid !== 1'b1 || note !== 3'd4) begin
      n_fail++; $display("FAIL timeout_prelock: got valid=%b note=%0d want 1 4", valid, note);
    end
    // tone_in held high: no further edges. j counts cycles since the last detected edge.
    j = 1;
    while (!no_tone && j < 3000) begin
      @(negedge clk);
      j++;
    end
    n_tests++; if (j < TMO - 1 || j > TMO + 1) begin
      n_fail++; $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", j, TMO - 1, TMO + 1);
    end
    n_tests++; if (valid !== 1'b0 || no_tone !== 1'b1 || note !== 3'd4 || period !== 10'd638) begin
      n_fail++; $display("FAIL timeout_state: got valid=%b no_tone=%b note=%0d period=%0d want 0 1 4 638",
                         valid, no_tone, note, period);
    end
    tone_in = 1'b0;
    repeat (20) @(negedge clk);
    q_per.delete(); q_val.delete(); q_note.delete();
    run_periods(319, 319, 3);
    close_rise();
    n_tests++; if (q_per.size() != 3 || q_val[0] !== 1'b0 || q_val[1] !== 1'b1 || q_val[2] !== 1'b1) begin
      n_fail++; $display("FAIL relock: got %0d updates want 3 with valid 0,1,1", q_per.size());
    end
    n_tests++; if (valid !== 1'b1 || note !== 3'd4 || no_tone !== 1'b0) begin
      n_fail++; $display("FAIL relock_state: got valid=%b note=%0d no_tone=%b want 1 4 0", valid, note, no_tone);
    end
  endtask

  task automatic test_jitter();
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      run_periods(321, 321, 1);
      run_periods(317, 317, 1);
    end
    close_rise();
    n_tests++;
    if (q_per.size() != 6) begin
      n_fail++; $display("FAIL jitter_updates: got %0d want 6", q_per.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_tests++; if (q_val[i] !== 1'b1 || q_note[i] !== 3'd4 ||
                       q_per[i] !== ((i % 2 == 0) ? 10'd642 : 10'd634)) begin
          n_fail++; $display("FAIL jitter[%0d]: got p=%0d v=%b n=%0d want p=%0d v=1 n=4", i,
                             q_per[i], q_val[i], q_note[i], (i % 2 == 0) ? 642 : 634);
        end
      end
    end
  endtask

  task automatic test_reset_mid_track();
    apply_reset();
    run_periods(239, 239, 2);
    close_rise();
    n_tests++; if (valid !== 1'b1 || note !== 3'd7 || period !== 10'd478) begin
      n_fail++; $display("FAIL mid_prelock: got valid=%b note=%0d period=%0d want 1 7 478", valid, note, period);
    end
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++; if (note !== 3'd0 || valid !== 1'b0 || no_tone !== 1'b1 || period !== '0 || update !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got note=%0d valid=%b no_tone=%b period=%0d update=%b want 0 0 1 0 0",
                         note, valid, no_tone, period, update);
    end
    tone_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    n_tests++; if (no_tone !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got no_tone=%b valid=%b want 1 0", no_tone, valid);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_note_change();
    test_tolerance();
    test_timeout();
    test_jitter();
    test_reset_mid_track();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
